axi_sim_mem_slave: RTL and testbench

- Single-port AXI4 slave memory model, used as a simulation target behind an AXI master or driver in block-level benches.
- Accepts write bursts into a byte-addressed backing array, honouring byte strobes.
- Returns stored data on read bursts, always with OKAY responses.
- Read and write paths are independent; each handles one outstanding burst at a time.

---
 rtl/axi_sim_mem_slave.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_axi_sim_mem_slave.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sim_mem_slave.sv
// AXI4 slave memory model for block-level simulation: byte-addressed backing array,
// one outstanding burst per direction, OKAY responses only.
module axi_sim_mem_slave #(
  parameter int unsigned AXI_ADDR_WIDTH     = 64,
  parameter int unsigned AXI_DATA_WIDTH     = 128,
  parameter int unsigned AXI_ID_WIDTH       = 6,
  parameter int unsigned AXI_USER_WIDTH     = 2,
  parameter int unsigned MEM_ADDR_WIDTH     = 16,
  parameter bit          WARN_UNINITIALIZED = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                  aw_len_i,
  input  logic [2:0]                  aw_size_i,
  input  logic [1:0]                  aw_burst_i,
  input  logic                        aw_lock_i,
  input  logic [3:0]                  aw_cache_i,
  input  logic [2:0]                  aw_prot_i,
  input  logic [3:0]                  aw_qos_i,
  input  logic [3:0]                  aw_region_i,
  input  logic [5:0]                  aw_atop_i,
  input  logic [AXI_USER_WIDTH-1:0]   aw_user_i,
  input  logic                        aw_valid_i,
  output logic                        aw_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                        w_last_i,
  input  logic [AXI_USER_WIDTH-1:0]   w_user_i,
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  output logic [AXI_ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]                  b_resp_o,
  output logic [AXI_USER_WIDTH-1:0]   b_user_o,
  output logic                        b_valid_o,
  input  logic                        b_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]                  ar_len_i,
  input  logic [2:0]                  ar_size_i,
  input  logic [1:0]                  ar_burst_i,
  input  logic                        ar_lock_i,
  input  logic [3:0]                  ar_cache_i,
  input  logic [2:0]                  ar_prot_i,
  input  logic [3:0]                  ar_qos_i,
  input  logic [3:0]                  ar_region_i,
  input  logic [AXI_USER_WIDTH-1:0]   ar_user_i,
  input  logic                        ar_valid_i,
  output logic                        ar_ready_o,
  output logic [AXI_ID_WIDTH-1:0]     r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]                  r_resp_o,
  output logic                        r_last_o,
  output logic [AXI_USER_WIDTH-1:0]   r_user_o,
  output logic                        r_valid_o,
  input  logic                        r_ready_i
);

  localparam int unsigned STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int unsigned MEM_SIZE = 1 << MEM_ADDR_WIDTH;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;

  typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
  typedef logic [MEM_ADDR_WIDTH-1:0] midx_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  // Address of beat idx; the first beat keeps its unaligned start address.
  function automatic addr_t beat_addr_f(input addr_t addr, input logic [2:0] size,
                                        input logic [7:0] len, input logic [1:0] burst,
                                        input logic [7:0] idx);
    addr_t nbytes, aligned, wrap_sz, wrap_lo, res;
    nbytes  = addr_t'(1) << size;
    aligned = addr & ~(nbytes - addr_t'(1));
    res     = aligned + (addr_t'(idx) << size);
    wrap_sz = (addr_t'(len) + addr_t'(1)) << size;
    wrap_lo = addr & ~(wrap_sz - addr_t'(1));
    if (burst == BURST_FIXED || idx == 8'd0) begin
      res = addr;
    end else if (burst == BURST_WRAP && res >= wrap_lo + wrap_sz) begin
      res = res - wrap_sz;
    end
    return res;
  endfunction

  logic [7:0]          mem_q [MEM_SIZE];
  logic [MEM_SIZE-1:0] written_q;

  // ---------------- write path ----------------
  wr_state_e                 wr_state_q, wr_state_d;
  logic [AXI_ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  addr_t                     aw_addr_q, aw_addr_d;
  logic [7:0]                aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]                aw_size_q, aw_size_d;
  logic [1:0]                aw_burst_q, aw_burst_d;
  logic                      aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d;
  logic                      aw_hs, w_hs, b_hs;
  addr_t                     w_addr;
  midx_t                     w_idx [STRB_W];

  assign aw_hs = aw_valid_i & aw_ready_q;
  assign w_hs  = w_valid_i & w_ready_q;
  assign b_hs  = b_valid_q & b_ready_i;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    case (wr_state_q)
      WR_IDLE: if (aw_hs) begin
        aw_id_d    = aw_id_i;
        aw_addr_d  = aw_addr_i;
        aw_len_d   = aw_len_i;
        aw_size_d  = aw_size_i;
        aw_burst_d = aw_burst_i;
        w_cnt_d    = 8'd0;
        wr_state_d = WR_DATA;
      end
      WR_DATA: if (w_hs) begin
        w_cnt_d = w_cnt_q + 8'd1;
        if (w_cnt_q == aw_len_q) wr_state_d = WR_RESP;
      end
      WR_RESP: if (b_hs) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
    aw_ready_d = (wr_state_d == WR_IDLE);
    w_ready_d  = (wr_state_d == WR_DATA);
    b_valid_d  = (wr_state_d == WR_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= WR_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
    end
  end

  assign w_addr = beat_addr_f(aw_addr_q, aw_size_q, aw_len_q, aw_burst_q, w_cnt_q);

  // Strobed lanes land on the bus-aligned word that holds the beat address.
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_w_idx
    assign w_idx[gi] = (w_addr[MEM_ADDR_WIDTH-1:0] & ~midx_t'(STRB_W - 1)) | midx_t'(gi);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      written_q <= '0;
    end else if (w_hs) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb_i[i]) begin
          mem_q[w_idx[i]]     <= w_data_i[8*i +: 8];
          written_q[w_idx[i]] <= 1'b1;
        end
      end
    end
  end

  // ---------------- read path ----------------
  rd_state_e                 rd_state_q, rd_state_d;
  logic [AXI_ID_WIDTH-1:0]   ar_id_q, ar_id_d;
  addr_t                     ar_addr_q, ar_addr_d;
  logic [7:0]                ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]                ar_size_q, ar_size_d;
  logic [1:0]                ar_burst_q, ar_burst_d;
  logic                      ar_ready_q, ar_ready_d, r_valid_q, r_valid_d;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d, ld_data;
  logic                      r_last_q, r_last_d;
  logic                      ar_hs, r_hs, rd_load, ld_last;
  addr_t                     ld_addr, ld_base, ld_hi;
  logic [2:0]                ld_size;
  addr_t                     ld_lane_addr [STRB_W];
  logic [STRB_W-1:0]         ld_lane_en, ld_lane_init;

  assign ar_hs = ar_valid_i & ar_ready_q;
  assign r_hs  = r_valid_q & r_ready_i;

  always_comb begin
    rd_state_d = rd_state_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_cnt_d    = r_cnt_q;
    rd_load    = 1'b0;
    ld_addr    = ar_addr_i;
    ld_size    = ar_size_i;
    ld_last    = 1'b0;
    case (rd_state_q)
      RD_IDLE: if (ar_hs) begin
        ar_id_d    = ar_id_i;
        ar_addr_d  = ar_addr_i;
        ar_len_d   = ar_len_i;
        ar_size_d  = ar_size_i;
        ar_burst_d = ar_burst_i;
        r_cnt_d    = 8'd0;
        rd_load    = 1'b1;
        ld_last    = (ar_len_i == 8'd0);
        rd_state_d = RD_DATA;
      end
      RD_DATA: if (r_hs) begin
        if (r_cnt_q == ar_len_q) begin
          rd_state_d = RD_IDLE;
        end else begin
          r_cnt_d = r_cnt_q + 8'd1;
          rd_load = 1'b1;
          ld_addr = beat_addr_f(ar_addr_q, ar_size_q, ar_len_q, ar_burst_q, r_cnt_d);
          ld_size = ar_size_q;
          ld_last = (r_cnt_d == ar_len_q);
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    ar_ready_d = (rd_state_d == RD_IDLE);
    r_valid_d  = (rd_state_d == RD_DATA);
  end

  // Only bytes from the beat address up to the end of its size-aligned window are returned.
  assign ld_base = ld_addr & ~addr_t'(STRB_W - 1);
  assign ld_hi   = (ld_addr & ~((addr_t'(1) << ld_size) - addr_t'(1))) + (addr_t'(1) << ld_size);

  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_rd_lane
    assign ld_lane_addr[gi] = ld_base + addr_t'(gi);
    assign ld_lane_en[gi]   = (ld_lane_addr[gi] >= ld_addr) && (ld_lane_addr[gi] < ld_hi);
    assign ld_lane_init[gi] = written_q[ld_lane_addr[gi][MEM_ADDR_WIDTH-1:0]];
    assign ld_data[8*gi +: 8] = (ld_lane_en[gi] && ld_lane_init[gi])
                              ? mem_q[ld_lane_addr[gi][MEM_ADDR_WIDTH-1:0]] : 8'h00;
  end

  always_comb begin
    r_data_d = r_data_q;
    r_last_d = r_last_q;
    if (rd_load) begin
      r_data_d = ld_data;
      r_last_d = ld_last;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= RD_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
      r_data_q   <= '0;
      r_last_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_cnt_q    <= r_cnt_d;
      r_data_q   <= r_data_d;
      r_last_q   <= r_last_d;
    end
  end

  if (WARN_UNINITIALIZED) begin : g_warn
    always_ff @(posedge clk_i) begin
      if (!rst_i && rd_load) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (ld_lane_en[i] && !ld_lane_init[i]) begin
            $warning("axi_sim_mem_slave: read of uninitialized byte at 0x%h", ld_lane_addr[i]);
          end
        end
      end
    end
  end

  assign aw_ready_o = aw_ready_q;
  assign w_ready_o  = w_ready_q;
  assign b_valid_o  = b_valid_q;
  assign b_id_o     = aw_id_q;
  assign b_resp_o   = 2'b00;
  assign b_user_o   = '0;
  assign ar_ready_o = ar_ready_q;
  assign r_valid_o  = r_valid_q;
  assign r_id_o     = ar_id_q;
  assign r_data_o   = r_data_q;
  assign r_last_o   = r_last_q;
  assign r_resp_o   = 2'b00;
  assign r_user_o   = '0;

  logic unused_ok;
  assign unused_ok = ^{aw_lock_i, aw_cache_i, aw_prot_i, aw_qos_i, aw_region_i, aw_atop_i,
                       aw_user_i, w_last_i, w_user_i, ar_lock_i, ar_cache_i, ar_prot_i,
                       ar_qos_i, ar_region_i, ar_user_i, w_addr[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

endmodule

// File: tb/tb_axi_sim_mem_slave.sv
// Directed + randomized bench for axi_sim_mem_slave against a byte-level memory model.
module tb_axi_sim_mem_slave;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   aw_id = '0, ar_id = '0;
  logic [63:0]  aw_addr = '0, ar_addr = '0;
  logic [7:0]   aw_len = '0, ar_len = '0;
  logic [2:0]   aw_size = '0, ar_size = '0, aw_prot = '0, ar_prot = '0;
  logic [1:0]   aw_burst = '0, ar_burst = '0, aw_user = '0, ar_user = '0, w_user = '0;
  logic         aw_lock = 1'b0, ar_lock = 1'b0;
  logic [3:0]   aw_cache = '0, aw_qos = '0, aw_region = '0, ar_cache = '0, ar_qos = '0, ar_region = '0;
  logic [5:0]   aw_atop = '0;
  logic         aw_valid = 1'b0, w_valid = 1'b0, ar_valid = 1'b0, b_ready = 1'b0, r_ready = 1'b0;
  logic [127:0] w_data = '0;
  logic [15:0]  w_strb = '0;
  logic         w_last = 1'b0;
  logic         aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
  logic [5:0]   b_id, r_id;
  logic [1:0]   b_resp, b_user, r_resp, r_user;
  logic [127:0] r_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] mem_m [int];

  always #5 clk = ~clk;

  axi_sim_mem_slave dut (
    .clk_i(clk), .rst_i(rst),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_size_i(aw_size),
    .aw_burst_i(aw_burst), .aw_lock_i(aw_lock), .aw_cache_i(aw_cache), .aw_prot_i(aw_prot),
    .aw_qos_i(aw_qos), .aw_region_i(aw_region), .aw_atop_i(aw_atop), .aw_user_i(aw_user),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last), .w_user_i(w_user),
    .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_id_o(b_id), .b_resp_o(b_resp), .b_user_o(b_user), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_size_i(ar_size),
    .ar_burst_i(ar_burst), .ar_lock_i(ar_lock), .ar_cache_i(ar_cache), .ar_prot_i(ar_prot),
    .ar_qos_i(ar_qos), .ar_region_i(ar_region), .ar_user_i(ar_user),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last), .r_user_o(r_user),
    .r_valid_o(r_valid), .r_ready_i(r_ready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  function automatic logic sig_of(input int ch);
    case (ch)
      0: return aw_ready;
      1: return w_ready;
      2: return b_valid;
      3: return ar_ready;
      default: return r_valid;
    endcase
  endfunction

  // Returns on a falling edge with the watched signal high.
  task automatic wait_high(input int ch, input string tag);
    int n = 0;
    @(negedge clk);
    while (!sig_of(ch)) begin
      n++;
      if (n > 2000) begin
        n_tests++;
        n_fail++;
        $error("FAIL %s timeout: observed 0 expected 1", tag);
        finish_tb();
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_hs(input int ch, input string tag);
    wait_high(ch, tag);
    @(posedge clk);
    #1;
  endtask

  // Beat address from the burst rules: FIXED holds, INCR steps by 2^size, WRAP is modular.
  function automatic longint unsigned beat_a(input longint unsigned a, input int size,
                                             input int len, input int burst, input int i);
    longint unsigned n    = 64'd1 << size;
    longint unsigned base = a - (a % n);
    longint unsigned span = n * longint'(len + 1);
    longint unsigned lo   = a - (a % span);
    if (burst == 0 || i == 0) return a;
    if (burst == 2) return lo + (((base - lo) + longint'(i) * n) % span);
    return base + longint'(i) * n;
  endfunction

  function automatic logic [15:0] lane_mask(input longint unsigned ba, input int size);
    longint unsigned n    = 64'd1 << size;
    longint unsigned hi   = ba - (ba % n) + n;
    longint unsigned base = ba - (ba % 16);
    logic [15:0] m = '0;
    for (int l = 0; l < 16; l++) begin
      if (base + longint'(l) >= ba && base + longint'(l) < hi) m[l] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [127:0] exp_rd(input longint unsigned ba, input int size);
    logic [127:0] d = '0;
    logic [15:0]  m = lane_mask(ba, size);
    longint unsigned base = ba - (ba % 16);
    for (int l = 0; l < 16; l++) begin
      int key = int'((base + longint'(l)) % 65536);
      if (m[l] && mem_m.exists(key)) d[l*8 +: 8] = mem_m[key];
    end
    return d;
  endfunction

  task automatic model_write(input longint unsigned ba, input logic [127:0] d, input logic [15:0] s);
    longint unsigned base = ba - (ba % 16);
    for (int l = 0; l < 16; l++) begin
      if (s[l]) mem_m[int'((base + longint'(l)) % 65536)] = d[l*8 +: 8];
    end
  endtask

  task automatic aw_send(input logic [5:0] id, input logic [63:0] a, input int len,
                         input int size, input int burst);
    aw_id = id; aw_addr = a; aw_len = 8'(len); aw_size = 3'(size); aw_burst = 2'(burst);
    aw_lock = 1'($urandom); aw_cache = 4'($urandom); aw_prot = 3'($urandom);
    aw_qos = 4'($urandom); aw_region = 4'($urandom); aw_atop = 6'($urandom); aw_user = 2'($urandom);
    aw_valid = 1'b1;
    wait_hs(0, "aw_handshake");
    aw_valid = 1'b0;
  endtask

  task automatic w_beat(input longint unsigned ba, input logic [127:0] d, input logic [15:0] s,
                        input logic last);
    w_data = d; w_strb = s; w_last = last; w_user = 2'($urandom);
    w_valid = 1'b1;
    wait_hs(1, "w_handshake");
    w_valid = 1'b0;
    model_write(ba, d, s);
  endtask

  task automatic b_collect(input logic [5:0] id, input int stall);
    wait_high(2, "b_valid");
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("b_hold_valid", 128'(b_valid), 128'(1));
      chk("b_hold_id", 128'(b_id), 128'(id));
    end
    b_ready = 1'b1;
    chk("b_id", 128'(b_id), 128'(id));
    chk("b_resp", 128'(b_resp), 128'(0));
    chk("b_user", 128'(b_user), 128'(0));
    @(posedge clk);
    #1;
    b_ready = 1'b0;
  endtask

  // smode: 0 all lanes, 1 random, 2 addressed lanes only, 3 fixed strobe fs
  task automatic wr_burst(input logic [5:0] id, input logic [63:0] a, input int len,
                          input int size, input int burst, input int smode,
                          input logic [15:0] fs, input bit use_fd, input logic [127:0] fd,
                          input int stall);
    logic [127:0] d;
    logic [15:0]  s;
    longint unsigned ba;
    $display("[TB] WR id=%h addr=%h len=%0d size=%0d burst=%0d", id, a, len, size, burst);
    aw_send(id, a, len, size, burst);
    for (int i = 0; i <= len; i++) begin
      ba = beat_a(a, size, len, burst, i);
      d  = use_fd ? fd : {$urandom, $urandom, $urandom, $urandom};
      case (smode)
        0: s = 16'hFFFF;
        1: s = 16'($urandom);
        2: s = lane_mask(ba, size);
        default: s = fs;
      endcase
      w_beat(ba, d, s, i == len);
    end
    b_collect(id, stall);
  endtask

  task automatic rd_burst(input logic [5:0] id, input logic [63:0] a, input int len,
                          input int size, input int burst, input int stall);
    logic [127:0] e;
    $display("[TB] RD id=%h addr=%h len=%0d size=%0d burst=%0d", id, a, len, size, burst);
    ar_id = id; ar_addr = a; ar_len = 8'(len); ar_size = 3'(size); ar_burst = 2'(burst);
    ar_lock = 1'($urandom); ar_cache = 4'($urandom); ar_prot = 3'($urandom);
    ar_qos = 4'($urandom); ar_region = 4'($urandom); ar_user = 2'($urandom);
    ar_valid = 1'b1;
    wait_hs(3, "ar_handshake");
    ar_valid = 1'b0;
    r_ready = (stall == 0);
    for (int i = 0; i <= len; i++) begin
      e = exp_rd(beat_a(a, size, len, burst, i), size);
      wait_high(4, "r_valid");
      if (i == 0) begin
        for (int k = 0; k < stall; k++) begin
          @(negedge clk);
          chk("r_hold_valid", 128'(r_valid), 128'(1));
          chk("r_hold_data", r_data, e);
          chk("r_hold_id", 128'(r_id), 128'(id));
        end
      end
      r_ready = 1'b1;
      chk($sformatf("r_data[%0d]", i), r_data, e);
      chk($sformatf("r_last[%0d]", i), 128'(r_last), 128'(i == len));
      chk("r_id", 128'(r_id), 128'(id));
      chk("r_resp_user", 128'({r_resp, r_user}), 128'(0));
      @(posedge clk);
      #1;
    end
    r_ready = 1'b0;
    chk("r_valid_after_last", 128'(r_valid), 128'(0));
  endtask

  task automatic check_all_idle_low(input string tag);
    chk({tag, "_aw_ready"}, 128'(aw_ready), 128'(0));
    chk({tag, "_w_ready"},  128'(w_ready),  128'(0));
    chk({tag, "_b_valid"},  128'(b_valid),  128'(0));
    chk({tag, "_ar_ready"}, 128'(ar_ready), 128'(0));
    chk({tag, "_r_valid"},  128'(r_valid),  128'(0));
  endtask

  initial begin
    logic [127:0] d_old, d_new, e_pre;
    logic [63:0]  a;
    int burst, size, len;
    int wlens [4] = '{1, 3, 7, 15};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_idle_low("reset");
    rst = 1'b0;
    mem_m.delete();
    @(posedge clk);
    #1;
    chk("post_reset_aw_ready", 128'(aw_ready), 128'(1));
    chk("post_reset_ar_ready", 128'(ar_ready), 128'(1));

    // Full-width INCR burst and readback
    wr_burst(6'($urandom), 64'h1000, 15, 4, 1, 0, '0, 1'b0, '0, 0);
    rd_burst(6'($urandom), 64'h1000, 15, 4, 1, 0);

    // Strobe merge
    wr_burst(6'h01, 64'h2000, 0, 4, 1, 0, '0, 1'b1, {16{8'hAA}}, 0);
    wr_burst(6'h02, 64'h2000, 0, 4, 1, 3, 16'h000F, 1'b1, {16{8'h55}}, 0);
    chk("strobe_model", exp_rd(64'h2000, 4), {{12{8'hAA}}, {4{8'h55}}});
    rd_burst(6'h03, 64'h2000, 0, 4, 1, 0);

    // Never-written location reads as zero
    chk("uninit_model", exp_rd(64'h8000, 4), 128'(0));
    rd_burst(6'h04, 64'h8000, 0, 4, 1, 0);

    // Narrow INCR write inside a pre-filled word
    wr_burst(6'h05, 64'h20, 0, 4, 1, 0, '0, 1'b0, '0, 0);
    wr_burst(6'h06, 64'h21, 3, 0, 1, 2, '0, 1'b0, '0, 0);
    rd_burst(6'h07, 64'h20, 0, 4, 1, 0);

    // Back-pressure on B and R, id echo
    wr_burst(6'h2A, 64'h3400, 3, 4, 1, 0, '0, 1'b0, '0, 5);
    rd_burst(6'h15, 64'h3400, 3, 4, 1, 5);

    // Maximum burst length
    wr_burst(6'h09, 64'h6000, 255, 0, 1, 2, '0, 1'b0, '0, 0);
    rd_burst(6'h0A, 64'h6000, 255, 0, 1, 0);

    // Same-cycle write and read of one word: read sees the old value
    d_old = {$urandom, $urandom, $urandom, $urandom};
    d_new = ~d_old;
    wr_burst(6'h0B, 64'h3000, 0, 4, 1, 0, '0, 1'b1, d_old, 0);
    aw_send(6'h0C, 64'h3000, 0, 4, 1);
    e_pre = exp_rd(64'h3000, 4);
    ar_id = 6'h0D; ar_addr = 64'h3000; ar_len = 8'd0; ar_size = 3'd4; ar_burst = 2'd1;
    w_data = d_new; w_strb = 16'hFFFF; w_last = 1'b1;
    ar_valid = 1'b1;
    w_valid  = 1'b1;
    $display("[TB] WR+RD same cycle addr=%h", 64'h3000);
    wait_high(1, "same_cycle_w_ready");
    chk("same_cycle_ar_ready", 128'(ar_ready), 128'(1));
    @(posedge clk);
    #1;
    ar_valid = 1'b0;
    w_valid  = 1'b0;
    model_write(64'h3000, d_new, 16'hFFFF);
    r_ready = 1'b1;
    wait_high(4, "same_cycle_r_valid");
    chk("same_cycle_r_data", r_data, e_pre);
    @(posedge clk);
    #1;
    r_ready = 1'b0;
    b_collect(6'h0C, 0);
    rd_burst(6'h0E, 64'h3000, 0, 4, 1, 0);

    // Randomized bursts with aliased upper address bits
    for (int t = 0; t < 24; t++) begin
      burst = $urandom_range(0, 3);
      size  = $urandom_range(0, 4);
      len   = (burst == 2) ? wlens[$urandom_range(0, 3)] : $urandom_range(0, 15);
      a     = ({$urandom, $urandom} & ~64'hFFFF) | 64'($urandom_range(0, 16'h3FFF));
      if (burst == 2) a = a & ~((64'd1 << size) - 64'd1);
      wr_burst(6'($urandom), a, len, size, burst, 1, '0, 1'b0, '0, 0);
      rd_burst(6'($urandom), a, len, size, burst, 0);
    end

    // Reset during a write burst
    aw_send(6'h11, 64'h5000, 7, 4, 1);
    for (int i = 0; i < 3; i++) begin
      w_beat(beat_a(64'h5000, 4, 7, 1, i), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b0);
    end
    $display("[TB] RESET mid-burst");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_idle_low("midreset");
    rst = 1'b0;
    mem_m.delete();
    @(posedge clk);
    #1;
    chk("midreset_aw_ready_next", 128'(aw_ready), 128'(1));
    chk("midreset_b_quiet", 128'(b_valid), 128'(0));
    rd_burst(6'h12, 64'h5000, 2, 4, 1, 0);
    wr_burst(6'h13, 64'h5000, 1, 4, 1, 0, '0, 1'b0, '0, 0);
    rd_burst(6'h14, 64'h5000, 2, 4, 1, 0);

    finish_tb();
  end

endmodule
